// File: rtl/filter_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module  : filter_sequencer_pkg
// Brief   : Opcodes, kernel size codes, field widths and command helpers.
// Revision: 1.0 - initial release
// ============================================================================
package filter_sequencer_pkg;

    localparam int c_kernel_w = 200;
    localparam int c_offset_w = 9;

    localparam logic [3:0] c_op_conv      = 4'b0101;
    localparam logic [3:0] c_op_conv_trsp = 4'b0110;
    localparam logic [3:0] c_op_conv_rob  = 4'b0111;
    localparam logic [3:0] c_op_b2g       = 4'b1000;

    localparam logic [1:0] c_size_2x2     = 2'b00;
    localparam logic [1:0] c_size_3x3     = 2'b01;
    localparam logic [1:0] c_size_illegal = 2'b10;
    localparam logic [1:0] c_size_5x5     = 2'b11;

    function automatic logic cmd_legal(input logic [1:0] size, input logic [3:0] opcode);
        return (size != c_size_illegal) &&
               (opcode inside {c_op_conv, c_op_conv_trsp, c_op_conv_rob, c_op_b2g});
    endfunction

    // Returns {lo, hi}: rows/cols at each image edge the kernel cannot cover.
    function automatic logic [3:0] scan_margins(input logic [1:0] size, input logic [3:0] opcode);
        logic [3:0] m;
        m = 4'h0;
        if (opcode != c_op_b2g) begin
            case (size)
                c_size_2x2: m = {2'd0, 2'd1};
                c_size_3x3: m = {2'd1, 2'd1};
                c_size_5x5: m = {2'd2, 2'd2};
                default:    m = 4'h0;
            endcase
        end
        return m;
    endfunction

endpackage
`default_nettype wire

// File: rtl/filter_sequencer_pixel_scan_counter.sv
`default_nettype none
// ============================================================================
// Module  : filter_sequencer_pixel_scan_counter
// Brief   : Raster row/col counter with border classification and pixel address.
// Revision: 1.0 - initial release
// ============================================================================
module filter_sequencer_pixel_scan_counter #(
    parameter int IMG_W  = 32,
    parameter int IMG_H  = 32,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              advance,
    input  logic [1:0]        lo,
    input  logic [1:0]        hi,
    output logic              is_border,
    output logic              is_last,
    output logic [ADDR_W-1:0] addr
);

    localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;

    logic [CW-1:0] r_col;
    logic [RW-1:0] r_row;
    logic          w_col_end;
    logic          w_row_end;
    logic [31:0]   w_col32;
    logic [31:0]   w_row32;

    assign w_col_end = (r_col == CW'(IMG_W - 1));
    assign w_row_end = (r_row == RW'(IMG_H - 1));
    assign w_col32   = 32'(r_col);
    assign w_row32   = 32'(r_row);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_col <= '0;
            r_row <= '0;
        end else if (clear) begin
            r_col <= '0;
            r_row <= '0;
        end else if (advance) begin
            if (w_col_end) begin
                r_col <= '0;
                r_row <= r_row + 1'b1;
            end else begin
                r_col <= r_col + 1'b1;
            end
        end
    end

    assign is_last   = w_col_end & w_row_end;
    assign is_border = (w_row32 < 32'(lo)) || (w_row32 + 32'(hi) > 32'(IMG_H - 1)) ||
                       (w_col32 < 32'(lo)) || (w_col32 + 32'(hi) > 32'(IMG_W - 1));
    assign addr      = ADDR_W'(w_row32 * 32'(IMG_W) + w_col32);

endmodule
`default_nettype wire

// File: rtl/filter_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : filter_sequencer
// Brief   : Walks the image, issues datapath ops for interior pixels, zero-writes
//           borders, tracks outstanding results and signals completion.
// Revision: 1.0 - initial release
// ============================================================================
module filter_sequencer
    import filter_sequencer_pkg::*;
#(
    parameter int IMG_W   = 32,
    parameter int IMG_H   = 32,
    parameter int ADDR_W  = 10,
    parameter int MAX_OUT = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [1:0]            cfg_size,
    input  logic [3:0]            cfg_opcode,
    input  logic [c_offset_w-1:0] cfg_initial_v,
    input  logic [c_kernel_w-1:0] cfg_kernel,
    output logic                  op_valid,
    input  logic                  op_ready,
    output logic [ADDR_W-1:0]     op_addr,
    output logic [3:0]            op_opcode,
    output logic [1:0]            op_size,
    output logic [c_offset_w-1:0] op_initial_v,
    output logic [c_kernel_w-1:0] op_kernel,
    input  logic                  res_valid,
    output logic                  wr_en,
    output logic [ADDR_W-1:0]     wr_addr,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    localparam int OW = $clog2(MAX_OUT + 1);

    localparam logic [2:0] c_st_idle  = 3'd0;
    localparam logic [2:0] c_st_load  = 3'd1;
    localparam logic [2:0] c_st_run   = 3'd2;
    localparam logic [2:0] c_st_drain = 3'd3;
    localparam logic [2:0] c_st_done  = 3'd4;

    logic [2:0]            r_state;
    logic [2:0]            w_state_nxt;
    logic [3:0]            r_opcode;
    logic [1:0]            r_size;
    logic [c_offset_w-1:0] r_initv;
    logic [c_kernel_w-1:0] r_kernel;
    logic                  r_err;
    logic [1:0]            r_lo;
    logic [1:0]            r_hi;
    logic [OW-1:0]         r_out;
    logic [OW-1:0]         w_out_nxt;
    logic                  w_run;
    logic                  w_hs;
    logic                  w_adv;
    logic                  w_res_live;
    logic                  w_res_dec;
    logic                  w_legal;
    logic                  w_is_border;
    logic                  w_is_last;
    logic [ADDR_W-1:0]     w_addr;
    logic [3:0]            w_margin;

    assign w_legal    = cmd_legal(cfg_size, cfg_opcode);
    assign w_margin   = scan_margins(r_size, r_opcode);
    assign w_run      = (r_state == c_st_run);
    assign op_valid   = w_run && !w_is_border && (r_out != OW'(MAX_OUT));
    assign wr_en      = w_run && w_is_border;
    assign w_hs       = op_valid && op_ready;
    assign w_adv      = w_hs || wr_en;
    // Results only count against a live command; stale ones after reset are dropped.
    assign w_res_live = res_valid && (w_run || (r_state == c_st_drain));
    assign w_res_dec  = w_res_live && (r_out != '0);

    always_comb begin
        w_out_nxt = r_out;
        if (w_hs && !w_res_dec) begin
            w_out_nxt = r_out + 1'b1;
        end else if (!w_hs && w_res_dec) begin
            w_out_nxt = r_out - 1'b1;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_idle:  if (start) w_state_nxt = w_legal ? c_st_load : c_st_done;
            c_st_load:  w_state_nxt = c_st_run;
            c_st_run:   if (w_adv && w_is_last) w_state_nxt = c_st_drain;
            c_st_drain: if (w_out_nxt == '0) w_state_nxt = c_st_done;
            c_st_done:  w_state_nxt = c_st_idle;
            default:    w_state_nxt = c_st_idle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= c_st_idle;
            r_opcode <= '0;
            r_size   <= '0;
            r_initv  <= '0;
            r_kernel <= '0;
            r_err    <= 1'b0;
            r_lo     <= '0;
            r_hi     <= '0;
            r_out    <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == c_st_idle && start) begin
                r_opcode <= cfg_opcode;
                r_size   <= cfg_size;
                r_initv  <= cfg_initial_v;
                r_kernel <= cfg_kernel;
                r_err    <= !w_legal;
            end else if (w_res_live && (r_out == '0)) begin
                r_err <= 1'b1;
            end
            if (r_state == c_st_load) begin
                r_lo  <= w_margin[3:2];
                r_hi  <= w_margin[1:0];
                r_out <= '0;
            end else begin
                r_out <= w_out_nxt;
            end
        end
    end

    filter_sequencer_pixel_scan_counter #(
        .IMG_W  (IMG_W),
        .IMG_H  (IMG_H),
        .ADDR_W (ADDR_W)
    ) u_scan (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (r_state == c_st_load),
        .advance   (w_adv),
        .lo        (r_lo),
        .hi        (r_hi),
        .is_border (w_is_border),
        .is_last   (w_is_last),
        .addr      (w_addr)
    );

    assign op_addr      = w_addr;
    assign wr_addr      = w_addr;
    assign op_opcode    = r_opcode;
    assign op_size      = r_size;
    assign op_initial_v = r_initv;
    assign op_kernel    = r_kernel;
    assign busy         = (r_state != c_st_idle);
    assign done         = (r_state == c_st_done);
    assign err          = r_err;

endmodule
`default_nettype wire
